// File: rtl/mem_stage_pkg.sv
// Shared pipeline constants for the MEM stage: datapath widths and the
// encoding of the data-memory access FSM.
package mem_stage_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int ADDR_WIDTH     = 8;
  localparam int IMM8_WIDTH     = 8;
  localparam int REG_WIDTH      = 4;
  localparam int TIMEOUT_CYCLES = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HELD = 2'd2
  } mem_state_e;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and
// the data memory (slave).
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) ();

  logic          dmem_req_o;
  logic          dmem_we_o;
  logic [AW-1:0] dmem_addr_o;
  logic [DW-1:0] dmem_wdata_o;
  logic          dmem_ack_i;
  logic [DW-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );

endinterface

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer (IDLE/WAIT/HELD). Optional wait timeout is
// compiled in when MEM_TIMEOUT_EN is defined.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op_i,
  input  logic ack_i,
  input  logic stall_i,
  output logic req_o,
  output logic busy_o,
  output logic capture_o,
  output logic use_buf_o,
  output logic abort_o
);

  mem_state_e state_q, state_d;
  logic       timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == ST_WAIT) && !ack_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT && !ack_i && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_o     = 1'b0;
    busy_o    = 1'b0;
    capture_o = 1'b0;
    use_buf_o = 1'b0;
    abort_o   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_o  = mem_op_i;
        busy_o = mem_op_i & ~ack_i;
        if (mem_op_i) begin
          if (!ack_i) begin
            state_d = ST_WAIT;
          end else if (stall_i) begin
            capture_o = 1'b1;
            state_d   = ST_HELD;
          end
        end
      end
      ST_WAIT: begin
        req_o  = 1'b1;
        busy_o = mem_op_i & ~ack_i;
        if (ack_i) begin
          if (stall_i) begin
            capture_o = 1'b1;
            state_d   = ST_HELD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timeout) begin
          // Give up on the access: the stage stops stalling and emits a bubble.
          req_o   = 1'b0;
          busy_o  = 1'b0;
          abort_o = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        use_buf_o = 1'b1;
        if (!stall_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: forwarding/branch muxes, data-memory access and the
// MEM/WB register. Optional access timeout: define MEM_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = mem_stage_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = mem_stage_pkg::ADDR_WIDTH,
  parameter int IMM8_WIDTH     = mem_stage_pkg::IMM8_WIDTH,
  parameter int REG_WIDTH      = mem_stage_pkg::REG_WIDTH,
  parameter int TIMEOUT_CYCLES = mem_stage_pkg::TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic [IMM8_WIDTH-1:0] imm8M_i,
  input  logic [REG_WIDTH-1:0]  WriteRegM_i,
  input  logic [DATA_WIDTH-1:0] alu_outM_i,
  input  logic                  RegWriteM_i,
  input  logic                  BranchM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic                  MemToRegM_i,
  input  logic                  MovM_i,
  input  logic                  flush_MEM_WB_i,
  input  logic                  stall_MEM_WB_i,
  output logic                  mem_busy_o,
  mem_stage_if.master           dmem,
  output logic [DATA_WIDTH-1:0] WBResultM_o,
  output logic                  PCSrcM_o,
  output logic [ADDR_WIDTH-1:0] PCBranchM_o,
  output logic [DATA_WIDTH-1:0] ResultW_o,
  output logic [REG_WIDTH-1:0]  WriteRegW_o,
  output logic                  RegWriteW_o,
  output logic                  mem_err_o
);

  logic mem_op, req, busy, capture, use_buf, abort;

  logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [REG_WIDTH-1:0]  wreg_q, wreg_d;
  logic                  regw_q, regw_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rd_data;

  assign mem_op      = MemReadM_i | MemWriteM_i;
  assign WBResultM_o = MovM_i ? {{(DATA_WIDTH-IMM8_WIDTH){1'b0}}, imm8M_i} : alu_outM_i;
  assign PCSrcM_o    = BranchM_i & (alu_outM_i == '0);
  assign PCBranchM_o = PCM_i + ADDR_WIDTH'(imm8M_i);

  assign dmem.dmem_req_o   = req;
  assign dmem.dmem_we_o    = MemWriteM_i & req;
  assign dmem.dmem_addr_o  = alu_outM_i[ADDR_WIDTH-1:0];
  assign dmem.dmem_wdata_o = WriteDataM_i;
  assign mem_busy_o        = busy;

  mem_access_fsm #(
    .TIMEOUT (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .mem_op_i  (mem_op),
    .ack_i     (dmem.dmem_ack_i),
    .stall_i   (stall_MEM_WB_i),
    .req_o     (req),
    .busy_o    (busy),
    .capture_o (capture),
    .use_buf_o (use_buf),
    .abort_o   (abort)
  );

  // Read data comes from the buffer once a stalled completion has parked it.
  assign rd_data = use_buf ? rbuf_q : dmem.dmem_rdata_i;

  always_comb begin
    rbuf_d   = capture ? dmem.dmem_rdata_i : rbuf_q;
    err_d    = abort;
    result_d = result_q;
    wreg_d   = wreg_q;
    regw_d   = regw_q;
    if (flush_MEM_WB_i) begin
      result_d = '0;
      wreg_d   = '0;
      regw_d   = 1'b0;
    end else if (stall_MEM_WB_i) begin
      result_d = result_q;
    end else if (busy || abort) begin
      result_d = '0;
      wreg_d   = '0;
      regw_d   = 1'b0;
    end else begin
      result_d = MemToRegM_i ? rd_data : WBResultM_o;
      wreg_d   = WriteRegM_i;
      regw_d   = RegWriteM_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rbuf_q   <= '0;
      result_q <= '0;
      wreg_q   <= '0;
      regw_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rbuf_q   <= rbuf_d;
      result_q <= result_d;
      wreg_q   <= wreg_d;
      regw_q   <= regw_d;
      err_q    <= err_d;
    end
  end

  assign ResultW_o   = result_q;
  assign WriteRegW_o = wreg_q;
  assign RegWriteW_o = regw_q;
  assign mem_err_o   = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; the timeout scenario is
// compiled in only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  PCM = '0;
  logic [15:0] WriteDataM = '0;
  logic [7:0]  imm8M = '0;
  logic [3:0]  WriteRegM = '0;
  logic [15:0] alu_outM = '0;
  logic        RegWriteM = 0, BranchM = 0, MemReadM = 0, MemWriteM = 0;
  logic        MemToRegM = 0, MovM = 0, flush = 0, stall = 0;
  logic        mem_busy, PCSrcM, RegWriteW, mem_err;
  logic [15:0] WBResultM, ResultW;
  logic [7:0]  PCBranchM;
  logic [3:0]  WriteRegW;

  int checks = 0;
  int errors = 0;

  mem_stage_if #(.DW(16), .AW(8)) dif ();

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .PCM_i          (PCM),
    .WriteDataM_i   (WriteDataM),
    .imm8M_i        (imm8M),
    .WriteRegM_i    (WriteRegM),
    .alu_outM_i     (alu_outM),
    .RegWriteM_i    (RegWriteM),
    .BranchM_i      (BranchM),
    .MemReadM_i     (MemReadM),
    .MemWriteM_i    (MemWriteM),
    .MemToRegM_i    (MemToRegM),
    .MovM_i         (MovM),
    .flush_MEM_WB_i (flush),
    .stall_MEM_WB_i (stall),
    .mem_busy_o     (mem_busy),
    .dmem           (dif),
    .WBResultM_o    (WBResultM),
    .PCSrcM_o       (PCSrcM),
    .PCBranchM_o    (PCBranchM),
    .ResultW_o      (ResultW),
    .WriteRegW_o    (WriteRegW),
    .RegWriteW_o    (RegWriteW),
    .mem_err_o      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    PCM = '0; WriteDataM = '0; imm8M = '0; WriteRegM = '0; alu_outM = '0;
    RegWriteM = 0; BranchM = 0; MemReadM = 0; MemWriteM = 0;
    MemToRegM = 0; MovM = 0; flush = 0; stall = 0;
    dif.dmem_ack_i = 1'b0; dif.dmem_rdata_i = '0;
  endtask

  initial begin
    int pulses;
    int pulse_at;
    clear_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_result", ResultW, 16'h0000);
    check("rst_wreg", 16'(WriteRegW), 16'h0);
    check("rst_regw", 16'(RegWriteW), 16'h0);
    check("rst_err", 16'(mem_err), 16'h0);
    check("rst_req", 16'(dif.dmem_req_o), 16'h0);

    // ALU pass-through
    alu_outM = 16'h0042; RegWriteM = 1; WriteRegM = 4'd3;
    #1;
    check("alu_wbres", WBResultM, 16'h0042);
    check("alu_noreq", 16'(dif.dmem_req_o), 16'h0);
    check("alu_busy", 16'(mem_busy), 16'h0);
    step();
    check("alu_result", ResultW, 16'h0042);
    check("alu_wreg", 16'(WriteRegW), 16'h3);
    check("alu_regw", 16'(RegWriteW), 16'h1);

    // Branch and mov
    clear_inputs();
    BranchM = 1; alu_outM = 16'h0000; PCM = 8'hF8; imm8M = 8'h10;
    #1;
    check("br_taken", 16'(PCSrcM), 16'h1);
    check("br_target", 16'(PCBranchM), 16'h0008);
    alu_outM = 16'h0005;
    #1;
    check("br_not_taken", 16'(PCSrcM), 16'h0);
    BranchM = 0; MovM = 1; imm8M = 8'h7F; alu_outM = 16'h1234;
    #1;
    check("mov_wbres", WBResultM, 16'h007F);
    step();

    // Load with 3 wait cycles
    clear_inputs();
    MemReadM = 1; MemToRegM = 1; RegWriteM = 1; WriteRegM = 4'd5; alu_outM = 16'h0010;
    #1;
    check("ld_req0", 16'(dif.dmem_req_o), 16'h1);
    check("ld_addr", 16'(dif.dmem_addr_o), 16'h0010);
    check("ld_we", 16'(dif.dmem_we_o), 16'h0);
    check("ld_busy1", 16'(mem_busy), 16'h1);
    step();
    check("ld_bubble1", 16'(RegWriteW), 16'h0);
    check("ld_req1", 16'(dif.dmem_req_o), 16'h1);
    check("ld_busy2", 16'(mem_busy), 16'h1);
    step();
    check("ld_bubble2", ResultW, 16'h0000);
    check("ld_busy3", 16'(mem_busy), 16'h1);
    dif.dmem_ack_i = 1'b1; dif.dmem_rdata_i = 16'hBEEF;
    #1;
    check("ld_busy_ack", 16'(mem_busy), 16'h0);
    check("ld_req_ack", 16'(dif.dmem_req_o), 16'h1);
    step();
    check("ld_result", ResultW, 16'hBEEF);
    check("ld_wreg", 16'(WriteRegW), 16'h5);
    check("ld_regw", 16'(RegWriteW), 16'h1);

    // Zero-wait store
    clear_inputs();
    MemWriteM = 1; alu_outM = 16'h0020; WriteDataM = 16'hA5A5; dif.dmem_ack_i = 1'b1;
    #1;
    check("st_req", 16'(dif.dmem_req_o), 16'h1);
    check("st_we", 16'(dif.dmem_we_o), 16'h1);
    check("st_addr", 16'(dif.dmem_addr_o), 16'h0020);
    check("st_wdata", dif.dmem_wdata_o, 16'hA5A5);
    check("st_busy", 16'(mem_busy), 16'h0);
    step();
    check("st_result", ResultW, 16'h0020);
    check("st_regw", 16'(RegWriteW), 16'h0);

    // Load acknowledged while MEM/WB is stalled for two cycles
    clear_inputs();
    MemReadM = 1; MemToRegM = 1; RegWriteM = 1; WriteRegM = 4'd7; alu_outM = 16'h0030;
    stall = 1; dif.dmem_ack_i = 1'b1; dif.dmem_rdata_i = 16'h1357;
    #1;
    check("hld_busy0", 16'(mem_busy), 16'h0);
    step();
    dif.dmem_ack_i = 1'b0; dif.dmem_rdata_i = 16'hFFFF;
    #1;
    check("hld_hold1", ResultW, 16'h0020);
    check("hld_noreq1", 16'(dif.dmem_req_o), 16'h0);
    check("hld_busy1", 16'(mem_busy), 16'h0);
    step();
    check("hld_hold2", ResultW, 16'h0020);
    check("hld_noreq2", 16'(dif.dmem_req_o), 16'h0);
    stall = 0;
    step();
    check("hld_result", ResultW, 16'h1357);
    check("hld_wreg", 16'(WriteRegW), 16'h7);
    check("hld_regw", 16'(RegWriteW), 16'h1);

    // Flush coinciding with a zero-wait load completion
    clear_inputs();
    MemReadM = 1; MemToRegM = 1; RegWriteM = 1; WriteRegM = 4'd9; alu_outM = 16'h0040;
    dif.dmem_ack_i = 1'b1; dif.dmem_rdata_i = 16'h2222; flush = 1;
    step();
    check("fl_result", ResultW, 16'h0000);
    check("fl_regw", 16'(RegWriteW), 16'h0);
    flush = 0; dif.dmem_ack_i = 1'b0;
    #1;
    check("fl_idle_req", 16'(dif.dmem_req_o), 16'h1);
    MemReadM = 0; MemToRegM = 0; RegWriteM = 1; WriteRegM = 4'd3; alu_outM = 16'h0042;
    step();
    check("fl_after_alu", ResultW, 16'h0042);

    // Stall holds MEM/WB over a waiting load; then reset mid-WAIT
    clear_inputs();
    MemReadM = 1; MemToRegM = 1; RegWriteM = 1; WriteRegM = 4'd6; alu_outM = 16'h0050; stall = 1;
    step();
    check("wt_hold", ResultW, 16'h0042);
    check("wt_req", 16'(dif.dmem_req_o), 16'h1);
    check("wt_busy", 16'(mem_busy), 16'h1);
    step();
    check("wt_hold2", 16'(RegWriteW), 16'h1);
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_req", 16'(dif.dmem_req_o), 16'h0);
    check("mrst_busy", 16'(mem_busy), 16'h0);
    check("mrst_result", ResultW, 16'h0000);
    check("mrst_wreg", 16'(WriteRegW), 16'h0);
    check("mrst_regw", 16'(RegWriteW), 16'h0);
    check("mrst_err", 16'(mem_err), 16'h0);

`ifdef MEM_TIMEOUT_EN
    // Load that is never acknowledged must abort after the wait limit
    clear_inputs();
    MemReadM = 1; MemToRegM = 1; RegWriteM = 1; WriteRegM = 4'd2; alu_outM = 16'h0060;
    pulses = 0;
    pulse_at = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_err) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
        check("to_regw", 16'(RegWriteW), 16'h0);
        MemReadM = 0;
      end
    end
    check("to_pulses", 16'(pulses), 16'h1);
    check("to_cycle", 16'(pulse_at), 16'(TIMEOUT_CYCLES));
`else
    pulses = 0;
    pulse_at = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Params: DATA_WIDTH 16, datapath width; ADDR_WIDTH 8, PC/data address width; IMM8_WIDTH 8, immediate width; REG_WIDTH 4, register index width; TIMEOUT_CYCLES 15, wait-cycle limit (used only with MEM_TIMEOUT_EN).
REQ-002 One clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-003 EX/MEM inputs: PCM_i in 8; WriteDataM_i in 16; imm8M_i in 8; WriteRegM_i in 4; alu_outM_i in 16; RegWriteM_i, BranchM_i, MemReadM_i, MemWriteM_i, MemToRegM_i, MovM_i in 1 each.
REQ-004 Hazard: flush_MEM_WB_i in 1; stall_MEM_WB_i in 1; mem_busy_o out 1, stall request to hazard unit.
REQ-005 Data memory: dmem_req_o out 1; dmem_we_o out 1; dmem_addr_o out 8; dmem_wdata_o out 16; dmem_ack_i in 1; dmem_rdata_i in 16.
REQ-006 Forward/branch: WBResultM_o out 16; PCSrcM_o out 1; PCBranchM_o out 8.
REQ-007 MEM/WB: ResultW_o out 16; WriteRegW_o out 4; RegWriteW_o out 1; mem_err_o out 1.

Function
REQ-008 WBResultM_o = MovM_i ? zero-extended imm8M_i : alu_outM_i, combinational.
REQ-009 PCSrcM_o = BranchM_i & (alu_outM_i == 0); PCBranchM_o = (PCM_i + imm8M_i) mod 256; combinational.
REQ-010 mem_op = MemReadM_i | MemWriteM_i; dmem_addr_o = alu_outM_i[7:0]; dmem_wdata_o = WriteDataM_i; dmem_we_o = MemWriteM_i & dmem_req_o.
REQ-011 FSM states IDLE, WAIT, HELD.
REQ-012 IDLE: mem_op -> dmem_req_o=1 same cycle; ack same cycle -> zero-wait completion; no ack -> WAIT.
REQ-013 WAIT: dmem_req_o held 1, address/data stable; on ack -> completion.
REQ-014 Completion: if stall_MEM_WB_i=0, MEM/WB loads, next IDLE; else dmem_rdata_i captured into read buffer, next HELD.
REQ-015 HELD: dmem_req_o=0, mem_busy_o=0; first cycle with stall_MEM_WB_i=0 loads MEM/WB from buffer, next IDLE.
REQ-016 mem_busy_o = mem_op & ~dmem_ack_i in IDLE/WAIT; 0 in HELD.
REQ-017 MEM/WB load value: ResultW_o = MemToRegM_i ? read data : WBResultM_o; WriteRegW_o = WriteRegM_i; RegWriteW_o = RegWriteM_i.
REQ-018 MEM/WB priority: rst > flush_MEM_WB_i (all zero) > stall_MEM_WB_i (hold) > mem_busy_o (bubble: all zero) > load.
REQ-019 flush_MEM_WB_i affects only MEM/WB register; FSM state unaffected; if flush coincides with completion, FSM still proceeds to IDLE and no result is written.
REQ-020 Non-memory instruction: single-cycle pass-through, no request.

Reset
REQ-021 rst: FSM -> IDLE, read buffer, ResultW_o, WriteRegW_o, RegWriteW_o, mem_err_o -> 0; dmem_req_o drops in the cycle after rst, even mid-WAIT.

Configuration
REQ-022 MEM_TIMEOUT_EN defined: counter increments each WAIT cycle; reaching TIMEOUT_CYCLES without ack -> abort: dmem_req_o drops, mem_err_o pulses 1 cycle, MEM/WB loads bubble, mem_busy_o=0, next IDLE.
REQ-023 MEM_TIMEOUT_EN undefined: no counter, mem_err_o tied 0, WAIT persists until ack.

Structure
REQ-024 Width parameters and FSM state encoding live in shared pipeline constants package.
REQ-025 FSM plus timeout counter in one sub-module mem_access_fsm; datapath muxes and MEM/WB register in mem_stage.

Verification
REQ-026 ALU op alu_out=0x0042, RegWrite=1, WriteReg=3 -> next cycle ResultW_o=0x0042, WriteRegW_o=3, no dmem_req_o.
REQ-027 Load addr 0x10, ack after 3 cycles with rdata 0xBEEF -> mem_busy_o high 3 cycles, bubbles into MEM/WB, then ResultW_o=0xBEEF.
REQ-028 Load ack while stall_MEM_WB_i=1 for 2 cycles -> HELD, no re-request, ResultW_o=rdata when stall drops.
REQ-029 Branch, alu_out=0, PCM=0xF8, imm8=0x10 -> PCSrcM_o=1, PCBranchM_o=0x08; Mov imm8=0x7F -> WBResultM_o=0x007F.
REQ-030 rst mid-WAIT -> dmem_req_o=0 next cycle, all outputs 0; with MEM_TIMEOUT_EN, no ack for 15 cycles -> mem_err_o single pulse, RegWriteW_o=0.
